// File: rtl/turf_mem_pkg.sv
// Shared types and constants for the TURF register-bus arbiter.
package turf_mem_pkg;

  localparam int TURF_ADR_WIDTH = 28;
  localparam int TURF_DAT_WIDTH = 32;

  localparam logic [TURF_DAT_WIDTH-1:0] TURF_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } turf_state_e;

endpackage

// File: rtl/turf_rr_select.sv
// Combinational round-robin priority encoder: the search starts just after
// the previous winner, so every requester gets a turn.
module turf_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (|(req_i & (N'(1) << ((int'(last_i) + k) % N)))) begin
        idx_o = IDX_W'((int'(last_i) + k) % N);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turf_mem_arbiter.sv
// Round-robin arbiter sharing one register bus among NUM_REQ requesters,
// with a bus timeout that returns TIMEOUT_DATA and flags an error.
module turf_mem_arbiter
  import turf_mem_pkg::*;
#(
  parameter int                         NUM_REQ      = 2,
  parameter int                         TIMEOUT      = 255,
  parameter logic [TURF_DAT_WIDTH-1:0]  TIMEOUT_DATA = TURF_TIMEOUT_DATA
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [NUM_REQ-1:0]                  s_en_i,
  input  logic [NUM_REQ-1:0]                  s_wr_i,
  input  logic [NUM_REQ*TURF_ADR_WIDTH-1:0]   s_adr_i,
  input  logic [NUM_REQ*TURF_DAT_WIDTH-1:0]   s_dat_i,
  output logic [NUM_REQ-1:0]                  s_ack_o,
  output logic [TURF_DAT_WIDTH-1:0]           s_dat_o,
  output logic                                s_err_o,
  output logic                                m_en_o,
  output logic                                m_wr_o,
  output logic [TURF_ADR_WIDTH-1:0]           m_adr_o,
  output logic [TURF_DAT_WIDTH-1:0]           m_dat_o,
  input  logic                                m_ack_i,
  input  logic [TURF_DAT_WIDTH-1:0]           m_dat_i,
  output logic [15:0]                         timeout_count_o,
  output logic [2:0]                          last_timeout_req_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  turf_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            grant_q, grant_d;
  logic [IDX_W-1:0]            last_grant_q, last_grant_d;
  logic                        wr_q, wr_d;
  logic [TURF_ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [TURF_DAT_WIDTH-1:0]   dat_q, dat_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        m_en_q, m_en_d;
  logic [NUM_REQ-1:0]          s_ack_q, s_ack_d;
  logic [TURF_DAT_WIDTH-1:0]   s_dat_q, s_dat_d;
  logic                        s_err_q, s_err_d;
  logic [15:0]                 to_cnt_q, to_cnt_d;
  logic [2:0]                  last_to_q, last_to_d;

  logic [IDX_W-1:0]            sel_idx;
  logic                        sel_any;

  turf_rr_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i  (s_en_i),
    .last_i (last_grant_q),
    .idx_o  (sel_idx),
    .any_o  (sel_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    cnt_d        = cnt_q;
    m_en_d       = m_en_q;
    s_ack_d      = '0;
    s_dat_d      = s_dat_q;
    s_err_d      = s_err_q;
    to_cnt_d     = to_cnt_q;
    last_to_d    = last_to_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_d = sel_idx;
          wr_d    = s_wr_i[sel_idx];
          adr_d   = s_adr_i[int'(sel_idx)*TURF_ADR_WIDTH +: TURF_ADR_WIDTH];
          dat_d   = s_dat_i[int'(sel_idx)*TURF_DAT_WIDTH +: TURF_DAT_WIDTH];
          cnt_d   = '0;
          m_en_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A target ack in the final timeout cycle still counts as a normal completion.
        if (m_ack_i) begin
          s_dat_d = m_dat_i;
          s_err_d = 1'b0;
          m_en_d  = 1'b0;
          s_ack_d = NUM_REQ'(1) << grant_q;
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          s_dat_d   = TIMEOUT_DATA;
          s_err_d   = 1'b1;
          m_en_d    = 1'b0;
          s_ack_d   = NUM_REQ'(1) << grant_q;
          last_to_d = 3'(grant_q);
          if (to_cnt_q != 16'hFFFF) begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        last_grant_d = grant_q;
        s_err_d      = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      wr_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      cnt_q        <= '0;
      m_en_q       <= 1'b0;
      s_ack_q      <= '0;
      s_dat_q      <= '0;
      s_err_q      <= 1'b0;
      to_cnt_q     <= '0;
      last_to_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      cnt_q        <= cnt_d;
      m_en_q       <= m_en_d;
      s_ack_q      <= s_ack_d;
      s_dat_q      <= s_dat_d;
      s_err_q      <= s_err_d;
      to_cnt_q     <= to_cnt_d;
      last_to_q    <= last_to_d;
    end
  end

  assign s_ack_o            = s_ack_q;
  assign s_dat_o            = s_dat_q;
  assign s_err_o            = s_err_q;
  assign m_en_o             = m_en_q;
  assign m_wr_o             = wr_q;
  assign m_adr_o            = adr_q;
  assign m_dat_o            = dat_q;
  assign timeout_count_o    = to_cnt_q;
  assign last_timeout_req_o = last_to_q;

endmodule

// File: tb/tb_turf_mem_arbiter.sv
// Directed bench for turf_mem_arbiter with a transaction-level reference model
// compared against the DUT every cycle.
module tb_turf_mem_arbiter;

  localparam int NR = 2;
  localparam int TO = 4;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic          aclk;
  logic          areset;
  logic [NR-1:0] s_en_i;
  logic [NR-1:0] s_wr_i;
  logic [NR*28-1:0] s_adr_i;
  logic [NR*32-1:0] s_dat_i;
  logic [NR-1:0] s_ack_o;
  logic [31:0]   s_dat_o;
  logic          s_err_o;
  logic          m_en_o;
  logic          m_wr_o;
  logic [27:0]   m_adr_o;
  logic [31:0]   m_dat_o;
  logic          m_ack_i;
  logic [31:0]   m_dat_i;
  logic [15:0]   timeout_count_o;
  logic [2:0]    last_timeout_req_o;

  turf_mem_arbiter #(
    .NUM_REQ      (NR),
    .TIMEOUT      (TO),
    .TIMEOUT_DATA (TO_DATA)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_en_i             (s_en_i),
    .s_wr_i             (s_wr_i),
    .s_adr_i            (s_adr_i),
    .s_dat_i            (s_dat_i),
    .s_ack_o            (s_ack_o),
    .s_dat_o            (s_dat_o),
    .s_err_o            (s_err_o),
    .m_en_o             (m_en_o),
    .m_wr_o             (m_wr_o),
    .m_adr_o            (m_adr_o),
    .m_dat_o            (m_dat_o),
    .m_ack_i            (m_ack_i),
    .m_dat_i            (m_dat_i),
    .timeout_count_o    (timeout_count_o),
    .last_timeout_req_o (last_timeout_req_o)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Requester agents: each holds its request for 'shots' transactions and
  // drops it for the cycle after every ack.
  int shots [NR];
  bit drop  [NR];

  initial forever begin
    @(posedge aclk); #1;
    for (int i = 0; i < NR; i++) begin
      if (s_ack_o[i] === 1'b1) begin
        drop[i] = 1'b1;
        if (shots[i] > 0) shots[i]--;
      end else if (drop[i]) begin
        drop[i]   = 1'b0;
        s_en_i[i] = 1'b0;
      end else begin
        s_en_i[i] = (shots[i] > 0);
      end
    end
  end

  // Target: acks in the tgt_delay-th cycle of a request (0 = never acks).
  int          tgt_delay = 1;
  logic [31:0] tgt_data  = '0;
  int          tgt_cnt   = 0;
  bit          tgt_given = 0;

  initial forever begin
    @(posedge aclk); #1;
    m_ack_i = 1'b0;
    if (m_en_o === 1'b1) begin
      if (!tgt_given) begin
        tgt_cnt++;
        if (tgt_delay != 0 && tgt_cnt == tgt_delay) begin
          m_ack_i   = 1'b1;
          m_dat_i   = tgt_data;
          tgt_given = 1'b1;
        end
      end
    end else begin
      tgt_cnt   = 0;
      tgt_given = 1'b0;
    end
  end

  // Reference model: one outstanding transaction, described by its owner and
  // how many cycles the target request has been shown.
  int          mdl_owner;
  int          mdl_age;
  int          mdl_last;
  int          mdl_cand;
  bit          mdl_done;
  logic        exp_men, exp_err, exp_wr;
  logic [1:0]  exp_ack;
  logic [27:0] exp_adr;
  logic [31:0] exp_wdat, exp_sdat;
  logic [15:0] exp_tocnt;
  logic [2:0]  exp_lastto;

  always @(posedge aclk) begin
    if (areset) begin
      mdl_owner = -1; mdl_age = 0; mdl_last = NR - 1; mdl_done = 0;
      exp_men = 0; exp_err = 0; exp_wr = 0; exp_ack = '0;
      exp_adr = '0; exp_wdat = '0; exp_sdat = '0; exp_tocnt = '0; exp_lastto = '0;
    end else if (mdl_done) begin
      mdl_done = 0;
      exp_ack  = '0;
      exp_err  = 0;
    end else if (mdl_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        mdl_cand = (mdl_last + k) % NR;
        if (mdl_owner < 0 && s_en_i[mdl_cand]) mdl_owner = mdl_cand;
      end
      if (mdl_owner >= 0) begin
        mdl_age  = 0;
        exp_men  = 1;
        exp_wr   = s_wr_i[mdl_owner];
        exp_adr  = s_adr_i[28*mdl_owner +: 28];
        exp_wdat = s_dat_i[32*mdl_owner +: 32];
      end
    end else begin
      mdl_age++;
      if (m_ack_i || (TO != 0 && mdl_age == TO)) begin
        exp_men = 0;
        exp_ack = '0;
        exp_ack[mdl_owner] = 1'b1;
        if (m_ack_i) begin
          exp_sdat = m_dat_i;
          exp_err  = 0;
        end else begin
          exp_sdat   = TO_DATA;
          exp_err    = 1;
          exp_lastto = 3'(mdl_owner);
          if (exp_tocnt != 16'hFFFF) exp_tocnt = exp_tocnt + 16'd1;
        end
        mdl_last  = mdl_owner;
        mdl_owner = -1;
        mdl_done  = 1;
      end
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      chk("m_en_o", 32'(m_en_o), 32'(exp_men));
      chk("s_ack_o", 32'(s_ack_o), 32'(exp_ack));
      chk("s_err_o", 32'(s_err_o), 32'(exp_err));
      chk("timeout_count_o", 32'(timeout_count_o), 32'(exp_tocnt));
      chk("last_timeout_req_o", 32'(last_timeout_req_o), 32'(exp_lastto));
      if (exp_men) begin
        chk("m_adr_o", 32'(m_adr_o), 32'(exp_adr));
        chk("m_dat_o", m_dat_o, exp_wdat);
        chk("m_wr_o", 32'(m_wr_o), 32'(exp_wr));
      end
      if (exp_ack != 0) chk("s_dat_o", s_dat_o, exp_sdat);
    end
  end

  task automatic wait_men(input string tag);
    bit got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge aclk);
      if (m_en_o === 1'b1) got = 1;
    end
    chk({tag, "_men_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_ack(input string tag, output int idx, output int men,
                          output logic [31:0] dat, output logic err);
    bit got = 0;
    idx = -1; men = 0; dat = '0; err = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge aclk);
      if (m_en_o === 1'b1) men++;
      if (s_ack_o !== 2'b00) begin
        got = 1;
        idx = (s_ack_o === 2'b01) ? 0 : (s_ack_o === 2'b10) ? 1 : -1;
        dat = s_dat_o;
        err = s_err_o;
      end
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      @(negedge aclk);
      chk({tag, "_ack_one_cycle"}, 32'(s_ack_o), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  int          idx, men;
  logic [31:0] dat;
  logic        err;
  int          grants [4];
  int          stray;

  initial begin
    areset  = 1'b1;
    s_en_i  = '0;
    s_wr_i  = '0;
    s_adr_i = '0;
    s_dat_i = '0;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    for (int i = 0; i < NR; i++) begin shots[i] = 0; drop[i] = 0; end
    @(posedge aclk); #1;
    chk_en = 1;
    idle(2);
    @(negedge aclk);
    chk("rst_m_en", 32'(m_en_o), 32'd0);
    chk("rst_s_ack", 32'(s_ack_o), 32'd0);
    chk("rst_tocnt", 32'(timeout_count_o), 32'd0);
    chk("rst_s_dat", s_dat_o, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    idle(2);

    // Single read from requester 0, acked in the 2nd request cycle.
    tgt_delay = 2; tgt_data = 32'h12345678;
    s_adr_i[27:0] = 28'h0000010; s_wr_i[0] = 1'b0; s_dat_i[31:0] = 32'h0000_0055;
    shots[0] = 1;
    wait_ack("rd", idx, men, dat, err);
    chk("rd_idx", 32'(idx), 32'd0);
    chk("rd_men_cycles", 32'(men), 32'd2);
    chk("rd_dat", dat, 32'h12345678);
    chk("rd_err", 32'(err), 32'd0);
    idle(3);

    // Write from requester 1; its inputs change while the grant is held.
    tgt_delay = 3; tgt_data = 32'h0;
    s_adr_i[55:28] = 28'h0ABCDEF; s_dat_i[63:32] = 32'hCAFEF00D; s_wr_i[1] = 1'b1;
    shots[1] = 1;
    wait_men("wr");
    @(posedge aclk); #1;
    s_adr_i[55:28] = 28'h1111111; s_dat_i[63:32] = 32'h0BAD0BAD; s_wr_i[1] = 1'b0;
    @(negedge aclk);
    chk("wr_hold_adr", 32'(m_adr_o), 32'h0ABCDEF);
    chk("wr_hold_dat", m_dat_o, 32'hCAFEF00D);
    chk("wr_hold_wr", 32'(m_wr_o), 32'd1);
    wait_ack("wr", idx, men, dat, err);
    chk("wr_idx", 32'(idx), 32'd1);
    idle(3);

    // Contention: both requesters ask twice each.
    tgt_delay = 1; tgt_data = 32'h0000_C0DE;
    s_adr_i[27:0] = 28'h0000100; s_adr_i[55:28] = 28'h0000200;
    s_dat_i[31:0] = 32'h1111_0000; s_dat_i[63:32] = 32'h2222_0000;
    shots[0] = 2; shots[1] = 2;
    for (int t = 0; t < 4; t++) begin
      wait_ack("cont", idx, men, dat, err);
      grants[t] = idx;
    end
    chk("cont_g0", 32'(grants[0]), 32'd0);
    chk("cont_g1", 32'(grants[1]), 32'd1);
    chk("cont_g2", 32'(grants[2]), 32'd0);
    chk("cont_g3", 32'(grants[3]), 32'd1);
    idle(3);

    // Timeout: the target never answers requester 1.
    tgt_delay = 0;
    shots[1] = 1;
    wait_ack("to", idx, men, dat, err);
    chk("to_idx", 32'(idx), 32'd1);
    chk("to_men_cycles", 32'(men), 32'd4);
    chk("to_dat", dat, 32'hDEADBEEF);
    chk("to_err", 32'(err), 32'd1);
    chk("to_count", 32'(timeout_count_o), 32'd1);
    chk("to_last_req", 32'(last_timeout_req_o), 32'd1);
    idle(3);

    // Ack in the last cycle before the timeout fires.
    tgt_delay = 4; tgt_data = 32'hA5A5A5A5;
    shots[0] = 1;
    wait_ack("bnd", idx, men, dat, err);
    chk("bnd_idx", 32'(idx), 32'd0);
    chk("bnd_men_cycles", 32'(men), 32'd4);
    chk("bnd_dat", dat, 32'hA5A5A5A5);
    chk("bnd_err", 32'(err), 32'd0);
    chk("bnd_count", 32'(timeout_count_o), 32'd1);
    idle(3);

    // Reset while the bus is busy.
    tgt_delay = 0;
    shots[1] = 1;
    wait_men("rb");
    @(posedge aclk); #1;
    areset = 1'b1;
    shots[0] = 0; shots[1] = 0; drop[0] = 0; drop[1] = 0;
    @(negedge aclk);
    @(negedge aclk);
    chk("rb_m_en", 32'(m_en_o), 32'd0);
    chk("rb_s_ack", 32'(s_ack_o), 32'd0);
    chk("rb_tocnt", 32'(timeout_count_o), 32'd0);
    chk("rb_last_to", 32'(last_timeout_req_o), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (s_ack_o !== 2'b00) stray++;
    end
    chk("rb_no_ack", 32'(stray), 32'd0);
    @(posedge aclk); #1;
    tgt_delay = 1; tgt_data = 32'h0000_0001;
    shots[0] = 1; shots[1] = 1;
    wait_ack("rb_first", idx, men, dat, err);
    chk("rb_first_idx", 32'(idx), 32'd0);
    wait_ack("rb_second", idx, men, dat, err);
    chk("rb_second_idx", 32'(idx), 32'd1);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/turf_mem_arbiter.md
# turf_mem_arbiter

Round-robin arbiter sharing the single aclk-domain register bus (en/wr/ack/adr/dat) among NUM_REQ requesters, e.g. the UDP read/write control path and local housekeeping/DMA masters. Each transaction is granted exclusively, forwarded to the target and terminated by the target ack or by a bus timeout. On timeout the block returns TIMEOUT_DATA and counts the event, so a missing target never hangs a requester.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (1..8).
- TIMEOUT, 255: max cycles in BUSY before forced termination; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports (one clock; reset is synchronous and active-high):
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- s_en_i  in  NUM_REQ  per-requester request, held high until its ack.
- s_wr_i  in  NUM_REQ  1 = write, 0 = read.
- s_adr_i  in  NUM_REQ*28  address, requester i at [28*i +: 28].
- s_dat_i  in  NUM_REQ*32  write data, requester i at [32*i +: 32].
- s_ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- s_dat_o  out  32  read data, broadcast, valid while s_ack_o is high.
- s_err_o  out  1  high with s_ack_o when the transaction timed out.
- m_en_o  out  1  target request.
- m_wr_o  out  1  target write strobe.
- m_adr_o  out  28  target address.
- m_dat_o  out  32  target write data.
- m_ack_i  in  1  target ack, single-cycle pulse.
- m_dat_i  in  32  target read data, valid with m_ack_i.
- timeout_count_o  out  16  saturating count of timeouts.
- last_timeout_req_o  out  3  index of the most recently timed-out requester.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any s_en_i is high, select the winner round-robin, starting at (last_grant+1) mod NUM_REQ. Register grant, wr, adr and dat from the winner, clear the timeout counter, then go to BUSY.
- BUSY: m_en_o=1. m_wr_o/adr/dat stay stable from the registered copy.
  - If m_ack_i is high: capture m_dat_i into s_dat_o, s_err_o=0, go to DONE.
  - Else, if TIMEOUT!=0 and the counter equals TIMEOUT-1: set s_dat_o=TIMEOUT_DATA and s_err_o=1, increment timeout_count_o (saturate at 16'hFFFF), set last_timeout_req_o=grant, go to DONE.
  - Otherwise increment the counter.
- DONE: m_en_o=0. s_ack_o[grant]=1 for exactly this cycle. last_grant<=grant, then go to IDLE.
- Requester rule: s_en_i must drop in the cycle after its s_ack_o. The grant is re-evaluated only in IDLE, so it never re-issues a completed request.
- Ignored inputs:
  - s_en_i deasserted mid-transaction: transaction still completes and acks.
  - m_ack_i outside BUSY.
  - Changes on the registered requester's inputs after grant.
- Reads: m_wr_o=0, but m_dat_o still carries the registered s_dat_i (don't-care to the target).

## Timing
- Reset: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), all outputs 0, counters 0.
- Reset mid-BUSY: m_en_o drops the next cycle and no s_ack_o is issued.
- Latency:
  - s_en_i sampled high at edge N → m_en_o high in cycle N+1.
  - m_ack_i sampled at edge K → s_ack_o high in cycle K+1.
  - Minimum request-to-ack is 3 cycles.
- Timeout: m_en_o is high for exactly TIMEOUT cycles, then DONE. If m_ack_i arrives in the final timeout cycle, ack wins and it is a normal completion.
- Back-to-back: a new grant is at the earliest 1 cycle after DONE. Per-requester throughput is at most one transaction per 3 cycles.
- All outputs are registered; there is no combinational path from s_* to m_* or from m_ack_i to s_ack_o.

## Structure
- Package turf_mem_pkg:
  - TURF_ADR_WIDTH=28, TURF_DAT_WIDTH=32.
  - state encoding typedef (IDLE/BUSY/DONE).
  - TIMEOUT_DATA default.
- Sub-module turf_rr_select: combinational round-robin priority encoder.
  - Inputs: req vector, last index.
  - Outputs: winner index, any.
  - Reusable for other shared resources.
- Timeout counter width: $clog2(TIMEOUT+1), minimum 1.

## Test plan
- Single read: req0 read adr 28'h0000010, target acks 2 cycles after m_en_o with 32'h12345678 → m_en_o high 2 cycles; s_ack_o=2'b01 for one cycle with s_dat_o=32'h12345678 and s_err_o=0.
- Contention: req0 and req1 both held continuously, each dropping en for one cycle after its ack → grants alternate 0,1,0,1. m_adr_o matches the granted requester each time, and no requester is granted twice in a row.
- Timeout: TIMEOUT=4, target never acks → m_en_o high exactly 4 cycles; s_ack_o pulse with s_dat_o=32'hDEADBEEF and s_err_o=1; timeout_count_o=1; last_timeout_req_o=the granted index.
- Ack on the boundary: TIMEOUT=4, m_ack_i in the 4th BUSY cycle with 32'hA5A5A5A5 → normal completion, s_err_o=0, timeout_count_o unchanged.
- Write and stability: req1 write adr 28'h0ABCDEF, data 32'hCAFEF00D; requester changes adr/dat during BUSY → m_adr_o/m_dat_o hold the original values, m_wr_o=1, s_ack_o=2'b10.
- Reset mid-BUSY: assert areset during BUSY → next cycle m_en_o=0, no s_ack_o, counters 0; first post-reset contention is won by requester 0.
